tetron_placer: RTL and testbench

TETRON_PLACER -- requirements
Module: tetron_placer

---
 rtl/tetron_pkg.sv | 20 ++
 rtl/tetron_coord_calc.sv | 33 +++
 rtl/tetron_placer.sv | 170 +++++++++++++++++
 tb/tb_tetron_placer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetron_pkg.sv
// Shared constants and FSM encoding for the tetron placement engine.
// Coordinates are widened internally so anchor+offset can never wrap.
package tetron_pkg;
    localparam int BOARD_W_DEF = 10;
    localparam int BOARD_H_DEF = 20;
    localparam int OFFSET_W    = 5;
    localparam int ANCHOR_W    = 5;
    localparam int COORD_W     = 7;
    localparam int X_W         = 4;
    localparam int Y_W         = 5;
    localparam int NBLK        = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        DRAIN  = 3'd2,
        COMMIT = 3'd3,
        DONE   = 3'd4
    } state_t;
endpackage

// File: rtl/tetron_coord_calc.sv
// Combinational anchor+offset calculator with playfield bounds check.
// The sum is formed at a width wide enough that no operand combination wraps.
module tetron_coord_calc
    import tetron_pkg::*;
#(
    parameter int BOARD_W = BOARD_W_DEF,
    parameter int BOARD_H = BOARD_H_DEF
) (
    input  logic [ANCHOR_W-1:0] anchor_x,
    input  logic [ANCHOR_W-1:0] anchor_y,
    input  logic [OFFSET_W-1:0] hoffset,
    input  logic [OFFSET_W-1:0] voffset,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic                oob
);
    localparam logic signed [COORD_W-1:0] X_LIM = COORD_W'(BOARD_W);
    localparam logic signed [COORD_W-1:0] Y_LIM = COORD_W'(BOARD_H);

    logic signed [COORD_W-1:0] sum_x;
    logic signed [COORD_W-1:0] sum_y;

    assign sum_x = $signed({{(COORD_W-ANCHOR_W){1'b0}}, anchor_x})
                 + $signed({{(COORD_W-OFFSET_W){hoffset[OFFSET_W-1]}}, hoffset});
    assign sum_y = $signed({{(COORD_W-ANCHOR_W){1'b0}}, anchor_y})
                 + $signed({{(COORD_W-OFFSET_W){voffset[OFFSET_W-1]}}, voffset});

    assign oob = sum_x[COORD_W-1] || sum_y[COORD_W-1]
              || (sum_x >= X_LIM) || (sum_y >= Y_LIM);

    assign x = sum_x[X_W-1:0];
    assign y = sum_y[Y_W-1:0];
endmodule

// File: rtl/tetron_placer.sv
// Checks a four-block tetron against the board through a 1-cycle-latency read
// port and, on request, commits it by writing its four cells.
module tetron_placer
    import tetron_pkg::*;
#(
    parameter int BOARD_W = BOARD_W_DEF,
    parameter int BOARD_H = BOARD_H_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    input  logic [ANCHOR_W-1:0] anchor_x,
    input  logic [ANCHOR_W-1:0] anchor_y,
    input  logic [OFFSET_W-1:0] blk1_hoffset,
    input  logic [OFFSET_W-1:0] blk1_voffset,
    input  logic [OFFSET_W-1:0] blk2_hoffset,
    input  logic [OFFSET_W-1:0] blk2_voffset,
    input  logic [OFFSET_W-1:0] blk3_hoffset,
    input  logic [OFFSET_W-1:0] blk3_voffset,
    input  logic [OFFSET_W-1:0] blk4_hoffset,
    input  logic [OFFSET_W-1:0] blk4_voffset,
    output logic                rd_en,
    output logic [X_W-1:0]      rd_x,
    output logic [Y_W-1:0]      rd_y,
    input  logic                rd_data,
    output logic                wr_en,
    output logic [X_W-1:0]      wr_x,
    output logic [Y_W-1:0]      wr_y,
    output logic                busy,
    output logic                done,
    output logic                collision
);
    state_t                state_reg, state_next;
    logic [1:0]            idx_reg, idx_next;
    logic                  collision_reg, collision_next;
    logic                  rd_pending_reg, rd_pending_next;
    logic                  mode_reg;
    logic [ANCHOR_W-1:0]   ax_reg, ay_reg;
    logic                  latch;
    logic                  hit;

    logic [OFFSET_W-1:0]   hoff_in  [NBLK];
    logic [OFFSET_W-1:0]   voff_in  [NBLK];
    logic [OFFSET_W-1:0]   blk_hoff [NBLK];
    logic [OFFSET_W-1:0]   blk_voff [NBLK];

    logic [X_W-1:0]        blk_x;
    logic [Y_W-1:0]        blk_y;
    logic                  blk_oob;

    assign hoff_in = '{blk1_hoffset, blk2_hoffset, blk3_hoffset, blk4_hoffset};
    assign voff_in = '{blk1_voffset, blk2_voffset, blk3_voffset, blk4_voffset};

    genvar gi;
    generate
        for (gi = 0; gi < NBLK; gi++) begin : g_blk
            logic [OFFSET_W-1:0] hoff_reg;
            logic [OFFSET_W-1:0] voff_reg;
            always_ff @(posedge clk) begin
                if (latch) begin
                    hoff_reg <= hoff_in[gi];
                    voff_reg <= voff_in[gi];
                end
            end
            assign blk_hoff[gi] = hoff_reg;
            assign blk_voff[gi] = voff_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (latch) begin
            ax_reg   <= anchor_x;
            ay_reg   <= anchor_y;
            mode_reg <= mode;
        end
    end

    // One calculator serves both the check and commit passes, indexed by block.
    tetron_coord_calc #(
        .BOARD_W (BOARD_W),
        .BOARD_H (BOARD_H)
    ) u_calc (
        .anchor_x (ax_reg),
        .anchor_y (ay_reg),
        .hoffset  (blk_hoff[idx_reg]),
        .voffset  (blk_voff[idx_reg]),
        .x        (blk_x),
        .y        (blk_y),
        .oob      (blk_oob)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            collision_reg  <= 1'b0;
            rd_pending_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            collision_reg  <= collision_next;
            rd_pending_reg <= rd_pending_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        collision_next  = collision_reg;
        rd_pending_next = 1'b0;
        latch           = 1'b0;
        rd_en           = 1'b0;
        rd_x            = '0;
        rd_y            = '0;
        wr_en           = 1'b0;
        wr_x            = '0;
        wr_y            = '0;
        // rd_data is only meaningful the cycle after a read was issued.
        hit             = rd_pending_reg & rd_data;

        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    latch          = 1'b1;
                    collision_next = 1'b0;
                    idx_next       = '0;
                    state_next     = CHECK;
                end
            end
            CHECK: begin
                collision_next = collision_reg | hit | blk_oob;
                if (!blk_oob) begin
                    rd_en           = 1'b1;
                    rd_x            = blk_x;
                    rd_y            = blk_y;
                    rd_pending_next = 1'b1;
                end
                idx_next = idx_reg + 2'd1;
                if (idx_reg == 2'(NBLK - 1)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                collision_next = collision_reg | hit;
                idx_next       = '0;
                state_next     = (mode_reg && !collision_next) ? COMMIT : DONE;
            end
            COMMIT: begin
                wr_en    = 1'b1;
                wr_x     = blk_x;
                wr_y     = blk_y;
                idx_next = idx_reg + 2'd1;
                if (idx_reg == 2'(NBLK - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);
    assign collision = collision_reg;
endmodule

// File: tb/tb_tetron_placer.sv
// Randomized bench for tetron_placer: a cycle-indexed schedule model predicts
// every output, a board memory answers reads, and directed cases pin literals.
module tb_tetron_placer;
    localparam int W    = 10;
    localparam int H    = 20;
    localparam int NCYC = 8192;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [4:0] anchor_x = '0;
    logic [4:0] anchor_y = '0;
    logic [4:0] h_drv [4];
    logic [4:0] v_drv [4];
    logic       rd_en, wr_en, busy, done, collision;
    logic [3:0] rd_x, wr_x;
    logic [4:0] rd_y, wr_y;
    logic       rd_data = 1'b0;
    logic       clr_req = 1'b0;

    tetron_placer #(.BOARD_W(W), .BOARD_H(H)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .anchor_x(anchor_x), .anchor_y(anchor_y),
        .blk1_hoffset(h_drv[0]), .blk1_voffset(v_drv[0]),
        .blk2_hoffset(h_drv[1]), .blk2_voffset(v_drv[1]),
        .blk3_hoffset(h_drv[2]), .blk3_voffset(v_drv[2]),
        .blk4_hoffset(h_drv[3]), .blk4_voffset(v_drv[3]),
        .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
        .busy(busy), .done(done), .collision(collision)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // expected behaviour per cycle
    bit e_busy [NCYC];
    bit e_done [NCYC];
    bit e_rd   [NCYC];
    bit e_wr   [NCYC];
    bit e_cchk [NCYC];
    bit e_coll [NCYC];
    bit e_zero [NCYC];
    int e_rx [NCYC];
    int e_ry [NCYC];
    int e_wx [NCYC];
    int e_wy [NCYC];
    int m_end = 0;
    bit m_coll = 1'b0;
    bit m_live = 1'b0;
    bit mboard [W][H];
    bit mem    [W][H];

    int rd_tq[$], rd_xq[$], rd_yq[$];
    int wr_tq[$], wr_xq[$], wr_yq[$];
    int done_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int sx(input logic [4:0] v);
        return v[4] ? int'(v) - 32 : int'(v);
    endfunction

    // Board memory: 1-cycle read latency, garbage when no read is pending.
    initial begin
        forever begin
            @(posedge clk);
            if (rd_en && int'(rd_x) < W && int'(rd_y) < H)
                rd_data <= mem[rd_x][rd_y];
            else
                rd_data <= 1'($urandom);
            if (clr_req) begin
                for (int x = 0; x < W; x++)
                    for (int y = 0; y < H; y++) mem[x][y] = 1'b0;
            end else if (wr_en && int'(wr_x) < W && int'(wr_y) < H) begin
                mem[wr_x][wr_y] = 1'b1;
            end
        end
    end

    // Reference model: on each edge decide what the coming cycles must show.
    initial begin
        int c, ex, ey, endt;
        bit coll, oob;
        forever begin
            @(posedge clk);
            c = cyc;
            if (clr_req) begin
                for (int x = 0; x < W; x++)
                    for (int y = 0; y < H; y++) mboard[x][y] = 1'b0;
            end
            if (c < NCYC && e_wr[c]) mboard[e_wx[c]][e_wy[c]] = 1'b1;
            if (rst) begin
                for (int t = c + 1; t <= c + 12 && t < NCYC; t++) begin
                    e_busy[t] = 0; e_done[t] = 0; e_rd[t] = 0;
                    e_wr[t] = 0; e_cchk[t] = 0; e_zero[t] = 0;
                end
                if (c + 1 < NCYC) e_zero[c+1] = 1'b1;
                m_end  = c;
                m_coll = 1'b0;
                m_live = 1'b1;
            end else if (m_live && start && c > m_end && c + 12 < NCYC) begin
                coll = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    ex  = int'(anchor_x) + sx(h_drv[k]);
                    ey  = int'(anchor_y) + sx(v_drv[k]);
                    oob = (ex < 0) || (ex >= W) || (ey < 0) || (ey >= H);
                    if (oob) coll = 1'b1;
                    else begin
                        if (mboard[ex][ey]) coll = 1'b1;
                        e_rd[c+1+k] = 1'b1; e_rx[c+1+k] = ex; e_ry[c+1+k] = ey;
                    end
                end
                if (mode && !coll) begin
                    endt = c + 10;
                    for (int k = 0; k < 4; k++) begin
                        e_wr[c+6+k] = 1'b1;
                        e_wx[c+6+k] = int'(anchor_x) + sx(h_drv[k]);
                        e_wy[c+6+k] = int'(anchor_y) + sx(v_drv[k]);
                    end
                end else begin
                    endt = c + 6;
                end
                for (int t = c + 1; t <= endt; t++) e_busy[t] = 1'b1;
                e_done[endt] = 1'b1;
                e_cchk[endt] = 1'b1;
                e_coll[endt] = coll;
                m_end  = endt;
                m_coll = coll;
            end
            cyc = cyc + 1;
        end
    end

    // Compare and log on the falling edge, away from the active edge.
    initial begin
        int t;
        forever begin
            @(negedge clk);
            t = cyc;
            if (m_live && t < NCYC) begin
                chk("busy", busy, e_busy[t]);
                chk("done", done, e_done[t]);
                chk("rd_en", rd_en, e_rd[t]);
                if (e_rd[t]) chk("rd_xy", {rd_x, rd_y}, {4'(e_rx[t]), 5'(e_ry[t])});
                chk("wr_en", wr_en, e_wr[t]);
                if (e_wr[t]) chk("wr_xy", {wr_x, wr_y}, {4'(e_wx[t]), 5'(e_wy[t])});
                if (e_cchk[t]) chk("coll_done", collision, e_coll[t]);
                else if (t > m_end) chk("coll_hold", collision, m_coll);
                if (e_zero[t]) chk("rst_addr", {rd_x, rd_y, wr_x, wr_y}, 18'd0);
                if (rd_en) begin rd_tq.push_back(t); rd_xq.push_back(rd_x); rd_yq.push_back(rd_y); end
                if (wr_en) begin wr_tq.push_back(t); wr_xq.push_back(wr_x); wr_yq.push_back(wr_y); end
                if (done) done_q.push_back(t);
            end
        end
    end

    task automatic clear_logs();
        rd_tq.delete(); rd_xq.delete(); rd_yq.delete();
        wr_tq.delete(); wr_xq.delete(); wr_yq.delete();
        done_q.delete();
    endtask

    task automatic set_std_offsets();
        h_drv[0] = 5'd0;  v_drv[0] = 5'd0;
        h_drv[1] = 5'd1;  v_drv[1] = 5'd0;
        h_drv[2] = 5'h1F; v_drv[2] = 5'd0;
        h_drv[3] = 5'h1F; v_drv[3] = 5'd1;
    endtask

    task automatic launch(input int ax, input int ay, input logic m, output int c0);
        @(negedge clk);
        anchor_x = 5'(ax); anchor_y = 5'(ay); mode = m; start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk(nm, busy, 1'b0);
        #1;
    endtask

    // Compare n logged accesses against literal (time offset, x, y) triples.
    task automatic expect_log(input string nm, input int tq[$], input int xq[$], input int yq[$],
                              input int c0, input int n, input int off[4], input int xs[4], input int ys[4]);
        chk({nm, "_count"}, tq.size(), n);
        for (int k = 0; k < n && k < tq.size(); k++)
            chk({nm, "_entry"}, {32'(tq[k] - c0), 16'(xq[k]), 16'(yq[k])},
                {32'(off[k]), 16'(xs[k]), 16'(ys[k])});
    endtask

    initial begin
        int c0, c1, s;
        for (int k = 0; k < 4; k++) begin h_drv[k] = '0; v_drv[k] = '0; end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {busy, done, collision, rd_en, wr_en, rd_x, rd_y, wr_x, wr_y}, '0);

        // check-only on an empty board
        set_std_offsets();
        clear_logs(); launch(4, 10, 1'b0, c0); wait_idle("t29_idle");
        expect_log("t29_rd", rd_tq, rd_xq, rd_yq, c0, 4, '{1, 2, 3, 4}, '{4, 5, 3, 3}, '{10, 10, 10, 11});
        chk("t29_ndone", done_q.size(), 1);
        if (done_q.size() > 0) chk("t29_done_t", done_q[0] - c0, 6);
        chk("t29_nwr", wr_tq.size(), 0);
        chk("t29_coll", collision, 1'b0);

        // block 3 and 4 off the left edge
        clear_logs(); launch(0, 10, 1'b1, c0); wait_idle("t31_idle");
        expect_log("t31_rd", rd_tq, rd_xq, rd_yq, c0, 2, '{1, 2, 0, 0}, '{0, 1, 0, 0}, '{10, 10, 0, 0});
        chk("t31_ndone", done_q.size(), 1);
        if (done_q.size() > 0) chk("t31_done_t", done_q[0] - c0, 6);
        chk("t31_nwr", wr_tq.size(), 0);
        chk("t31_coll", collision, 1'b1);

        // check then commit
        clear_logs(); launch(4, 10, 1'b1, c0); wait_idle("t30_idle");
        expect_log("t30_wr", wr_tq, wr_xq, wr_yq, c0, 4, '{6, 7, 8, 9}, '{4, 5, 3, 3}, '{10, 10, 10, 11});
        chk("t30_ndone", done_q.size(), 1);
        if (done_q.size() > 0) chk("t30_done_t", done_q[0] - c0, 10);
        chk("t30_coll", collision, 1'b0);

        // same placement again now hits occupied cells
        clear_logs(); launch(4, 10, 1'b1, c0); wait_idle("t32_idle");
        chk("t32_nrd", rd_tq.size(), 4);
        chk("t32_ndone", done_q.size(), 1);
        if (done_q.size() > 0) chk("t32_done_t", done_q[0] - c0, 6);
        chk("t32_nwr", wr_tq.size(), 0);
        chk("t32_coll", collision, 1'b1);

        // start while busy is ignored; start right after done is taken
        clear_logs(); launch(7, 2, 1'b1, c0);
        @(negedge clk);
        anchor_x = 5'd0; anchor_y = 5'd0; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c0 + 7) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c0 + 11) @(negedge clk);
        anchor_x = 5'd7; anchor_y = 5'd5; mode = 1'b0; start = 1'b1; c1 = cyc;
        @(negedge clk);
        start = 1'b0;
        wait_idle("t33_idle");
        expect_log("t33_wr", wr_tq, wr_xq, wr_yq, c0, 4, '{6, 7, 8, 9}, '{7, 8, 6, 6}, '{2, 2, 2, 3});
        chk("t33_ndone", done_q.size(), 2);
        if (done_q.size() > 1) chk("t33_done_t", {32'(done_q[0] - c0), 32'(done_q[1] - c0)}, {32'd10, 32'd17});
        chk("t33_nrd", rd_tq.size(), 8);
        if (rd_tq.size() > 4) chk("t33_rd2", {32'(rd_tq[4] - c0), 16'(rd_xq[4]), 16'(rd_yq[4])}, {32'd12, 16'd7, 16'd5});

        // reset in the middle of a commit
        clear_logs(); launch(1, 15, 1'b1, c0);
        while (cyc < c0 + 7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t34_busy", busy, 1'b0);
        repeat (4) @(negedge clk);
        #1;
        expect_log("t34_wr", wr_tq, wr_xq, wr_yq, c0, 2, '{6, 7, 0, 0}, '{1, 2, 0, 0}, '{15, 15, 0, 0});
        chk("t34_ndone", done_q.size(), 0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 2) != 0);
            mode  = 1'($urandom);
            clr_req = (!busy && !start && $urandom_range(0, 39) == 0);
            if ($urandom_range(0, 7) == 0) begin
                anchor_x = 5'($urandom); anchor_y = 5'($urandom);
            end else begin
                anchor_x = 5'($urandom_range(0, 11)); anchor_y = 5'($urandom_range(0, 21));
            end
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 5) == 0) begin
                    h_drv[k] = 5'($urandom); v_drv[k] = 5'($urandom);
                end else begin
                    s = $urandom_range(0, 6) - 3; h_drv[k] = 5'(s);
                    s = $urandom_range(0, 6) - 3; v_drv[k] = 5'(s);
                end
            end
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0; clr_req = 1'b0;
        repeat (15) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
